// File: rtl/sdpram_burst_reader_pkg.sv
// Shared definitions for the port-B burst reader of the simple dual port RAM.
//   DATA_WIDTH_DEF / ADDR_WIDTH_DEF : default RAM word and address widths
//   RD_BUF_DEPTH                    : entries in the read-return buffer
//   rd_state_t                      : reader FSM state encoding
package sdpram_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int RD_BUF_DEPTH   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/sdpram_burst_reader_rd_buf_fifo.sv
// Read-return buffer: small synchronous FIFO holding RAM words tagged with a
// last-of-burst flag.
//   clk, rst : clock, synchronous active-high reset (flushes all entries)
//   push     : write wdata (ignored when full)
//   wdata    : {last, data}
//   pop      : drop head entry (ignored when empty)
//   rdata    : head entry
//   full     : all DEPTH entries occupied
//   empty    : no entries
//   count    : current occupancy, 0..DEPTH
module rd_buf_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/sdpram_burst_reader.sv
// Port-B burst reader: on start, reads len consecutive words (wrapping at the
// top of memory) from start_addr and streams them on a valid/ready interface.
//   clk, rst              : clock, synchronous active-high reset
//   start/start_addr/len  : burst request, sampled only in IDLE
//   busy, done            : burst in progress / one-cycle completion pulse
//   renb, addrb, doutb    : RAM port B (registered enable/address, 1-cycle data)
//   m_valid/m_data/m_last : stream output, m_ready from the sink
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing RAM reads under buffer credit
// DRAIN | all reads issued, emptying buffer until final handshake
// DONE  | one-cycle done pulse
module sdpram_burst_reader
  import sdpram_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  renb,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] doutb,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  localparam int CNT_W = $clog2(RD_BUF_DEPTH) + 1;

  rd_state_t             state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addrb_q;
  logic [LEN_WIDTH-1:0]  issue_cnt_q;
  logic [LEN_WIDTH-1:0]  out_cnt_q;
  logic                  renb_q;
  logic                  renb_last_q;
  logic                  pend_q;
  logic                  pend_last_q;

  logic [DATA_WIDTH:0]   fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  hs;
  logic [CNT_W:0]        committed;
  logic                  can_issue;

  // pend_q marks the cycle doutb is valid; the word is pushed at its end.
  rd_buf_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (RD_BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (pend_q),
    .wdata ({pend_last_q, doutb}),
    .pop   (hs),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_valid = !fifo_empty;
  assign m_data  = fifo_empty ? '0 : fifo_rdata[DATA_WIDTH-1:0];
  assign m_last  = !fifo_empty && fifo_rdata[DATA_WIDTH];
  assign hs      = m_valid && m_ready;
  assign busy    = (state_q == READ) || (state_q == DRAIN);
  assign done    = (state_q == DONE);
  assign renb    = renb_q;
  assign addrb   = addrb_q;

  // Slots claimed after this edge: buffer minus the word leaving now, the word
  // landing now, the read on the RAM bus, and the read being decided.
  assign committed = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(pend_q) +
                     (CNT_W+1)'(renb_q) + (CNT_W+1)'(1) - (CNT_W+1)'(hs);
  assign can_issue = (issue_cnt_q != '0) && (committed < (CNT_W+1)'(RD_BUF_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      addrb_q     <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      renb_q      <= 1'b0;
      renb_last_q <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      renb_q      <= 1'b0;
      pend_q      <= renb_q;
      pend_last_q <= renb_last_q;
      if (hs) out_cnt_q <= out_cnt_q - 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              // First read goes out immediately to meet the start->renb latency.
              state_q     <= READ;
              renb_q      <= 1'b1;
              renb_last_q <= (len == LEN_WIDTH'(1));
              addrb_q     <= start_addr;
              addr_q      <= start_addr + 1'b1;
              issue_cnt_q <= len - 1'b1;
              out_cnt_q   <= len;
            end else begin
              state_q <= DONE;
            end
          end
        end
        READ: begin
          if (can_issue) begin
            renb_q      <= 1'b1;
            renb_last_q <= (issue_cnt_q == LEN_WIDTH'(1));
            addrb_q     <= addr_q;
            addr_q      <= addr_q + 1'b1;
            issue_cnt_q <= issue_cnt_q - 1'b1;
          end
          if (issue_cnt_q == '0) state_q <= DRAIN;
        end
        DRAIN: begin
          if (hs && m_last) state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(pend_q && fifo_full && !hs))
        else $error("read buffer overflow");
      assert (!m_valid || (m_last == (out_cnt_q == LEN_WIDTH'(1))))
        else $error("m_last disagrees with remaining word count");
    end
  end

endmodule

// File: tb/tb_sdpram_burst_reader.sv
module tb_sdpram_burst_reader;

  logic        clk = 1'b0;
  logic        rst, start, m_ready;
  logic [7:0]  start_addr;
  logic [8:0]  len;
  logic        busy, done, renb, m_valid, m_last;
  logic [7:0]  addrb;
  logic [31:0] doutb, m_data;

  always #5 clk = ~clk;

  sdpram_burst_reader dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
    .busy(busy), .done(done), .renb(renb), .addrb(addrb), .doutb(doutb),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
  );

  // RAM port B with one-cycle read latency; port A writes are direct array writes.
  logic [31:0] mem [256];
  always @(posedge clk) if (renb) doutb <= mem[addrb];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_total = 0;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference model: expected words and expected read addresses per burst.
  logic [32:0] exp_q[$];
  logic [7:0]  exp_addr[$];
  int          zero_done_cyc = -10;
  int          outstanding = 0;
  int          hs_total = 0, n_last = 0, n_done = 0;
  logic        prev_stall = 0, last_hs_prev = 0, prev_last = 0;
  logic [31:0] prev_data = 0;
  int          ready_mode = 0;

  always @(negedge clk) begin
    logic        hs;
    logic [32:0] e;
    if (rst) begin
      exp_q.delete(); exp_addr.delete();
      outstanding = 0; prev_stall = 0; last_hs_prev = 0;
    end else begin
      hs = m_valid && m_ready;
      if (renb) begin
        if (exp_addr.size() == 0) check("spurious_renb", 1, 0);
        else check("addrb", addrb, exp_addr.pop_front());
        outstanding++;
      end
      if (hs) outstanding--;
      check("outstanding_le4", outstanding <= 4, 1);
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
        check("hold_last", m_last, prev_last);
      end
      check("done", done, last_hs_prev || (cyc == zero_done_cyc));
      if (hs) begin
        hs_total++;
        if (m_last) n_last++;
        if (exp_q.size() == 0) check("extra_word", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("m_data", m_data, e[31:0]);
          check("m_last", m_last, e[32]);
        end
      end
      if (done) n_done++;
      last_hs_prev = hs && m_last;
      prev_stall   = m_valid && !m_ready;
      prev_data    = m_data;
      prev_last    = m_last;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 1) m_ready = ~m_ready;
      else if (ready_mode == 2) m_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic start_burst(input logic [7:0] a, input logic [8:0] l);
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; len = l;
    for (int i = 0; i < int'(l); i++) begin
      exp_q.push_back({(i == int'(l) - 1), mem[8'(int'(a) + i)]});
      exp_addr.push_back(8'(int'(a) + i));
    end
    if (l == 0) zero_done_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < maxc);
    if (!done) check("timeout_done", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int base, n;
    int last0, done0;
    rst = 1; start = 0; start_addr = 0; len = 0; m_ready = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h5500_0000 + i;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_outputs", {busy, done, renb, addrb, m_valid, m_data, m_last}, 64'd0);

    // Basic burst
    for (int i = 0; i < 4; i++) mem[8'h10 + i] = 32'hA0 + i;
    m_ready = 1;
    start_burst(8'h10, 9'd4);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k <= 6) check("basic_busy", busy, 1);
      if (k == 1) begin check("basic_renb1", renb, 1); check("basic_addr1", addrb, 8'h10); end
      if (k == 2) check("basic_nvalid2", m_valid, 0);
      if (k == 3) begin check("basic_v3", m_valid, 1); check("basic_d3", m_data, 32'hA0); check("basic_l3", m_last, 0); end
      if (k == 6) begin check("basic_d6", m_data, 32'hA3); check("basic_l6", m_last, 1); end
      if (k == 7) begin check("basic_done7", done, 1); check("basic_busy7", busy, 0); end
    end
    @(posedge clk); #1;

    // Zero length
    start_burst(8'h50, 9'd0);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      check("zl_done", done, k == 1);
      check("zl_quiet", {busy, renb, m_valid}, 0);
    end
    @(posedge clk); #1;

    // Address wrap
    mem[8'hFE] = 1; mem[8'hFF] = 2; mem[8'h00] = 3; mem[8'h01] = 4;
    start_burst(8'hFE, 9'd4);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) check("wrap_addr1", addrb, 8'hFE);
      if (k == 3) check("wrap_addr3", addrb, 8'h00);
      if (k == 4) begin check("wrap_renb4", renb, 1); check("wrap_addr4", addrb, 8'h01); end
      if (k == 6) begin check("wrap_d6", m_data, 32'd4); check("wrap_l6", m_last, 1); end
      if (k == 7) check("wrap_done7", done, 1);
    end
    @(posedge clk); #1;

    // Backpressure
    for (int i = 0; i < 16; i++) mem[8'h40 + i] = 32'h1000 + 3 * i;
    m_ready = 0;
    start_burst(8'h40, 9'd16);
    for (int k = 1; k <= 10; k++) @(negedge clk);
    check("bp_stall_renb", renb, 0);
    check("bp_stall_valid", m_valid, 1);
    check("bp_stall_data", m_data, 32'h1000);
    check("bp_busy", busy, 1);
    ready_mode = 1;
    wait_done(300);
    ready_mode = 0; m_ready = 1;
    check("bp_all_words", exp_q.size(), 0);

    // start mid-burst is ignored
    for (int i = 0; i < 8; i++) mem[8'h30 + i] = 32'hC300 + i;
    start_burst(8'h30, 9'd8);
    repeat (2) @(posedge clk);
    #1 start = 1; start_addr = 8'h00; len = 9'd5;
    repeat (2) @(posedge clk);
    #1 start = 0;
    wait_done(100);
    for (int k = 0; k < 3; k++) begin @(negedge clk); check("mid_no_restart", {busy, renb}, 0); end
    check("mid_all_words", exp_q.size(), 0);
    @(posedge clk); #1;

    // Reset after 3 of 8 words
    for (int i = 0; i < 8; i++) mem[8'h60 + i] = 32'hD600 + i;
    start_burst(8'h60, 9'd8);
    base = hs_total; n = 0;
    do begin @(negedge clk); #1; n++; end while (hs_total - base < 3 && n < 50);
    if (hs_total - base < 3) check("timeout_rst_mid", 0, 1);
    done0 = n_done;
    @(posedge clk); #1 rst = 1; m_ready = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("rst_mid_outputs", {busy, done, renb, addrb, m_valid, m_data, m_last}, 64'd0);
    repeat (3) @(negedge clk);
    check("rst_mid_no_done", n_done - done0, 0);
    @(posedge clk); #1;

    // New burst after reset
    mem[8'h20] = 32'hBEEF_0000; mem[8'h21] = 32'hBEEF_0001;
    m_ready = 1;
    start_burst(8'h20, 9'd2);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 3) begin check("post_d3", m_data, 32'hBEEF_0000); check("post_l3", m_last, 0); end
      if (k == 4) begin check("post_d4", m_data, 32'hBEEF_0001); check("post_l4", m_last, 1); end
      if (k == 5) check("post_done5", done, 1);
    end
    @(posedge clk); #1;

    // Full-memory stress with random backpressure
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    last0 = n_last; done0 = n_done;
    ready_mode = 2;
    start_burst(8'h00, 9'd256);
    wait_done(3000);
    ready_mode = 0; m_ready = 1;
    repeat (3) @(negedge clk);
    check("stress_one_last", n_last - last0, 1);
    check("stress_one_done", n_done - done0, 1);
    check("stress_all_words", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sdpram_burst_reader.md
Name: sdpram_burst_reader

Overview:
- Read-side master for port B of the simple dual port RAM (renb/addrb in, doutb out).
- On a start command it reads len consecutive words from start_addr and streams them out on a valid/ready interface.
- It is the consumer that pairs with the port-A writers. It sits between the RAM and any downstream stream sink.

Parameters:
- DATA_WIDTH, 32, width of RAM word and m_data.
- ADDR_WIDTH, 8, RAM address width; MEM_DEPTH = 2**ADDR_WIDTH.
- LEN_WIDTH, ADDR_WIDTH+1, width of len, so a burst can cover the whole memory.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  burst request; sampled only in IDLE.
- start_addr  in  ADDR_WIDTH  first address of the burst.
- len  in  LEN_WIDTH  number of words to read.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when the burst is complete.
- renb  out  1  RAM port B read enable, driven from a register.
- addrb  out  ADDR_WIDTH  RAM port B address, driven from a register.
- doutb  in  DATA_WIDTH  RAM read data; valid the cycle after renb=1.
- m_valid  out  1  stream data valid.
- m_data  out  DATA_WIDTH  stream data.
- m_last  out  1  marks the final word of the burst.
- m_ready  in  1  stream sink ready.

Behaviour:
- Reset (rst=1 at a clock edge): all outputs are 0 in the following cycle. State goes to IDLE, counters clear, read buffer is flushed. Reset mid-burst discards in-flight and buffered data with no done pulse.
- States:
  - IDLE: start=1 and len>0 -> READ; latch addr=start_addr, issue_cnt=len, out_cnt=len.
  - IDLE: start=1 and len==0 -> DONE; no renb, no m_valid.
  - READ: when issue_cnt reaches 0 -> DRAIN.
  - DRAIN: final handshake (m_valid & m_ready & m_last) -> DONE.
  - DONE: one cycle, done=1, then -> IDLE.
- busy=1 in READ and DRAIN. busy=0 in DONE and IDLE.
- start is ignored whenever state != IDLE.
- Read issue: renb=1 in a cycle only if issue_cnt>0 and (buffer occupancy + reads in flight + read being issued) < RD_BUF_DEPTH (4). Each issued read increments addr and decrements issue_cnt.
- Address wrap: addrb wraps modulo 2**ADDR_WIDTH (0xFF -> 0x00 at ADDR_WIDTH=8). len > MEM_DEPTH is legal and re-reads wrapped addresses.
- RAM latency: doutb is valid exactly one cycle after renb. The reader writes doutb into the buffer at the end of that cycle.
- Latency: start sampled at the edge ending cycle T -> renb=1 in T+1 -> doutb valid in T+2 -> m_valid=1 in T+3.
- Throughput: with m_ready held at 1, one word per cycle is sustained for the whole burst with no bubbles.
- Stream rules:
  - m_data and m_last stay stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a handshake.
  - A word is transferred on m_valid & m_ready.
- m_last=1 exactly on the word where out_cnt==1. out_cnt decrements on each handshake.
- Buffer overflow must be impossible; the credit rule prevents it. Assert this in simulation.
- done timing: done pulses in the cycle after the final handshake. For len==0, done pulses in T+1.

Decomposition:
- Package sdpram_pkg:
  - default DATA_WIDTH and ADDR_WIDTH;
  - localparam RD_BUF_DEPTH=4;
  - typedef enum rd_state_t {IDLE, READ, DRAIN, DONE}.
- Sub-module rd_buf_fifo: synchronous FIFO, RD_BUF_DEPTH entries of DATA_WIDTH+1 bits (data plus last flag).
  - Ports: push/pop/full/empty/count.
  - Same clk/rst, synchronous active-high reset.
- Top level holds the FSM, counters, addrb register and credit logic.

Test Plan:
- Basic burst: preload mem[0x10..0x13]=0xA0..0xA3 via port A; start_addr=0x10, len=4, m_ready=1.
  -> m_data A0,A1,A2,A3 in cycles T+3..T+6.
  -> m_last only with A3; done=1 in T+7; busy=1 in T+1..T+6.
- Wrap: mem[0xFE,0xFF,0x00,0x01]=1,2,3,4; start_addr=0xFE, len=4.
  -> addrb sequence FE,FF,00,01; output 1,2,3,4 in order.
- Backpressure: len=16, m_ready low for 10 cycles, then toggling 1/0.
  -> all 16 words in order, none lost or duplicated.
  -> at most 4 reads outstanding or buffered; renb stalls while full; m_data stable during stall.
- Zero length: start with len=0.
  -> done=1 in T+1; renb, m_valid and busy stay 0.
- Control corner cases:
  - start asserted mid-burst -> ignored; current burst completes unchanged.
  - rst asserted after 3 of 8 words -> all outputs 0 next cycle, no done pulse.
  - new burst (0x20, len 2) afterwards -> correct data.
- Full-memory stress: random RAM contents, len=256 from 0x00, random m_ready.
  -> every word matches the bench reference memory using case-equality; exactly one m_last and one done.
